// File: rtl/bean_ctrl_fsm_if.sv
// bean_ctrl_fsm_if: control-unit to datapath/memory signal bundle
interface bean_ctrl_fsm_if;
  logic [31:0] instr;
  logic        branch_flag;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        reg_WE;
  logic        rs1_SEL;
  logic        rs2_SEL;
  logic        addrs_SEL;
  logic [1:0]  reg_SEL;
  logic [1:0]  pc_SEL;
  logic [2:0]  imm_SEL;
  logic [3:0]  ALU_MODE;
  logic        pc_EN;
  logic        instr_EN;
  logic        ALU_mem_EN;
  logic        mem_in_EN;
  logic        illegal;
  modport master (
    input  instr, branch_flag, mem_ready,
    output mem_req, mem_we, reg_WE, rs1_SEL, rs2_SEL, addrs_SEL, reg_SEL, pc_SEL,
           imm_SEL, ALU_MODE, pc_EN, instr_EN, ALU_mem_EN, mem_in_EN, illegal
  );
  modport slave (
    output instr, branch_flag, mem_ready,
    input  mem_req, mem_we, reg_WE, rs1_SEL, rs2_SEL, addrs_SEL, reg_SEL, pc_SEL,
           imm_SEL, ALU_MODE, pc_EN, instr_EN, ALU_mem_EN, mem_in_EN, illegal
  );
endinterface

// File: rtl/bean_ctrl_fsm.sv
// bean_ctrl_fsm: multicycle RV32I control unit with memory req/ready handshake
module bean_ctrl_fsm #(
  parameter int RESET_HOLD = 1
) (
  input logic            clk,
  input logic            reset,
  bean_ctrl_fsm_if.master bus
);
  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC, S_BRANCH, S_MEM_RD, S_MEM_WR, S_TRAP
  } state_t;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                         ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_EQ = 4'd10, ALU_PASS_B = 4'd11;
  state_t state, nxt;
  logic [3:0] cnt;
  logic [6:0] op;
  logic [2:0] f3;
  logic       i30;
  logic [2:0] imm_fmt;
  logic [3:0] alu_op;
  state_t     dec_nxt;
  logic       exec_ok;
  logic       unused_bits;
  assign op  = bus.instr[6:0];
  assign f3  = bus.instr[14:12];
  assign i30 = bus.instr[30];
  assign unused_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RESET;
      cnt   <= 4'd0;
    end else begin
      state <= nxt;
      cnt   <= (state == S_RESET && cnt != 4'(RESET_HOLD)) ? cnt + 4'd1 : cnt;
    end
  end
  always_comb begin
    alu_op = ALU_ADD;
    case (f3)
      3'b000:  alu_op = (op == OP_REG && i30) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = i30 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  end
  assign imm_fmt = (op == OP_STORE)                    ? IMM_S :
                   (op == OP_BRANCH)                   ? IMM_B :
                   (op == OP_LUI || op == OP_AUIPC)    ? IMM_U :
                   (op == OP_JAL)                      ? IMM_J : IMM_I;
  assign exec_ok = op == OP_LUI || op == OP_AUIPC || op == OP_JAL || op == OP_REG ||
                   op == OP_IMM || (op == OP_JALR && f3 == 3'b000) ||
                   (op == OP_FENCE && f3 == 3'b000);
  assign dec_nxt = (op == OP_LOAD)   ? ((f3 == 3'b010) ? S_MEM_RD : S_TRAP) :
                   (op == OP_STORE)  ? ((f3 == 3'b010) ? S_MEM_WR : S_TRAP) :
                   (op == OP_BRANCH) ? ((f3[2:1] != 2'b01) ? S_BRANCH : S_TRAP) :
                   exec_ok           ? S_EXEC : S_TRAP;
  always_comb begin
    nxt            = state;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.reg_WE     = 1'b0;
    bus.rs1_SEL    = 1'b0;
    bus.rs2_SEL    = 1'b0;
    bus.addrs_SEL  = 1'b0;
    bus.reg_SEL    = 2'd0;
    bus.pc_SEL     = 2'd0;
    bus.imm_SEL    = IMM_I;
    bus.ALU_MODE   = ALU_ADD;
    bus.pc_EN      = 1'b0;
    bus.instr_EN   = 1'b0;
    bus.ALU_mem_EN = 1'b0;
    bus.mem_in_EN  = 1'b0;
    bus.illegal    = 1'b0;
    case (state)
      S_RESET: nxt = (cnt == 4'(RESET_HOLD)) ? S_FETCH : S_RESET;
      S_FETCH: begin
        bus.addrs_SEL = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_in_EN = 1'b1;
        bus.instr_EN  = bus.mem_ready;
        nxt           = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        bus.imm_SEL = imm_fmt;
        nxt         = dec_nxt;
      end
      S_EXEC: begin
        bus.pc_EN    = 1'b1;
        bus.imm_SEL  = imm_fmt;
        bus.rs1_SEL  = op == OP_AUIPC;
        bus.rs2_SEL  = op == OP_IMM || op == OP_AUIPC || op == OP_JALR;
        bus.reg_SEL  = (op == OP_LUI) ? 2'd2 :
                       (op == OP_JAL || op == OP_JALR) ? 2'd3 :
                       (op == OP_REG || op == OP_IMM || op == OP_AUIPC) ? 2'd1 : 2'd0;
        bus.pc_SEL   = (op == OP_JAL) ? 2'd2 : (op == OP_JALR) ? 2'd1 : 2'd0;
        bus.reg_WE   = op != OP_FENCE;
        bus.ALU_MODE = (op == OP_REG || op == OP_IMM) ? alu_op : ALU_ADD;
        nxt          = S_FETCH;
      end
      S_BRANCH: begin
        bus.imm_SEL  = IMM_B;
        bus.pc_EN    = 1'b1;
        bus.ALU_MODE = !f3[2] ? ALU_EQ : f3[1] ? ALU_SLTU : ALU_SLT;
        bus.pc_SEL   = (bus.branch_flag ^ f3[0]) ? 2'd2 : 2'd0;
        nxt          = S_FETCH;
      end
      S_MEM_RD: begin
        bus.mem_req   = 1'b1;
        bus.mem_in_EN = 1'b1;
        bus.reg_WE    = bus.mem_ready;
        bus.pc_EN     = bus.mem_ready;
        nxt           = bus.mem_ready ? S_FETCH : S_MEM_RD;
      end
      S_MEM_WR: begin
        bus.mem_req    = 1'b1;
        bus.mem_we     = 1'b1;
        bus.ALU_mem_EN = 1'b1;
        bus.ALU_MODE   = ALU_PASS_B;
        bus.pc_EN      = bus.mem_ready;
        nxt            = bus.mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_TRAP: bus.illegal = 1'b1;
      default: nxt = S_TRAP;
    endcase
  end
endmodule

// File: tb/tb_bean_ctrl_fsm.sv
// tb_bean_ctrl_fsm: scoreboard bench for the BEAN-1 control unit
module tb_bean_ctrl_fsm;
  typedef struct packed {
    logic       mem_req, mem_we, reg_we, rs1, rs2, addrs;
    logic [1:0] reg_sel, pc_sel;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       pc_en, instr_en, alu_mem_en, mem_in_en, illegal;
  } outs_t;
  typedef struct {
    string tag;
    outs_t e;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  outs_t obs;
  always #5 clk = ~clk;
  bean_ctrl_fsm_if bus();
  bean_ctrl_fsm #(.RESET_HOLD(1)) dut (.clk(clk), .reset(reset), .bus(bus.master));
  assign obs = {bus.mem_req, bus.mem_we, bus.reg_WE, bus.rs1_SEL, bus.rs2_SEL, bus.addrs_SEL,
                bus.reg_SEL, bus.pc_SEL, bus.imm_SEL, bus.ALU_MODE, bus.pc_EN, bus.instr_EN,
                bus.ALU_mem_EN, bus.mem_in_EN, bus.illegal};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic outs_t fetch(input logic r);
    outs_t o = '0;
    o.mem_req = 1; o.addrs = 1; o.mem_in_en = 1; o.instr_en = r;
    return o;
  endfunction
  function automatic outs_t dec(input logic [2:0] m);
    outs_t o = '0;
    o.imm = m;
    return o;
  endfunction
  function automatic outs_t ex(input logic [3:0] a, input logic r1, input logic r2,
                               input logic [1:0] rs, input logic [1:0] ps,
                               input logic [2:0] m, input logic we);
    outs_t o = '0;
    o.alu = a; o.rs1 = r1; o.rs2 = r2; o.reg_sel = rs; o.pc_sel = ps;
    o.imm = m; o.reg_we = we; o.pc_en = 1;
    return o;
  endfunction
  function automatic outs_t mrd(input logic r);
    outs_t o = '0;
    o.mem_req = 1; o.mem_in_en = 1; o.reg_we = r; o.pc_en = r;
    return o;
  endfunction
  function automatic outs_t mwr(input logic r);
    outs_t o = '0;
    o.mem_req = 1; o.mem_we = 1; o.alu_mem_en = 1; o.alu = 4'd11; o.pc_en = r;
    return o;
  endfunction
  function automatic outs_t trap();
    outs_t o = '0;
    o.illegal = 1;
    return o;
  endfunction
  task automatic cyc(input string tag, input logic r, input logic [31:0] i, input logic f,
                     input logic rd, input outs_t e);
    exp_t x;
    @(posedge clk);
    #1;
    reset = r;
    bus.instr = i;
    bus.branch_flag = f;
    bus.mem_ready = rd;
    x.tag = tag;
    x.e = e;
    sb.push_back(x);
  endtask
  task automatic fd(input string tag, input logic [31:0] i, input logic [2:0] m);
    cyc({tag, "_fetch"}, 0, i, 0, 1, fetch(1));
    cyc({tag, "_dec"}, 0, i, 0, 1, dec(m));
  endtask
  always @(negedge clk) begin
    exp_t x;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk(x.tag, 32'(obs), 32'(x.e));
      chk({x.tag, "_inv_en"}, 32'(obs.mem_in_en & obs.alu_mem_en), 32'd0);
      chk({x.tag, "_inv_we"}, 32'(obs.mem_we & ~obs.mem_req), 32'd0);
    end
  end
  initial begin
    bus.instr = '0;
    bus.branch_flag = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (3) cyc("rst", 1, 0, 0, 1, '0);
    cyc("hold0", 0, 0, 0, 1, '0);
    cyc("hold1", 0, 0, 0, 1, '0);
    fd("addi", 32'h00500093, 3'd0);
    cyc("addi_ex", 0, 32'h00500093, 0, 1, ex(4'd0, 0, 1, 2'd1, 2'd0, 3'd0, 1));
    repeat (2) cyc("sub_wait", 0, 32'h40208033, 0, 0, fetch(0));
    fd("sub", 32'h40208033, 3'd0);
    cyc("sub_ex", 0, 32'h40208033, 0, 0, ex(4'd1, 0, 0, 2'd1, 2'd0, 3'd0, 1));
    fd("srai", 32'h4010d093, 3'd0);
    cyc("srai_ex", 0, 32'h4010d093, 0, 0, ex(4'd9, 0, 1, 2'd1, 2'd0, 3'd0, 1));
    fd("lui", 32'h123450b7, 3'd3);
    cyc("lui_ex", 0, 32'h123450b7, 0, 0, ex(4'd0, 0, 0, 2'd2, 2'd0, 3'd3, 1));
    fd("auipc", 32'h00001097, 3'd3);
    cyc("auipc_ex", 0, 32'h00001097, 0, 0, ex(4'd0, 1, 1, 2'd1, 2'd0, 3'd3, 1));
    fd("jal", 32'h008000ef, 3'd4);
    cyc("jal_ex", 0, 32'h008000ef, 0, 0, ex(4'd0, 0, 0, 2'd3, 2'd2, 3'd4, 1));
    fd("jalr", 32'h000080e7, 3'd0);
    cyc("jalr_ex", 0, 32'h000080e7, 0, 0, ex(4'd0, 0, 1, 2'd3, 2'd1, 3'd0, 1));
    fd("fence", 32'h0000000f, 3'd0);
    cyc("fence_ex", 0, 32'h0000000f, 0, 0, ex(4'd0, 0, 0, 2'd0, 2'd0, 3'd0, 0));
    fd("bne_nt", 32'h00209463, 3'd2);
    cyc("bne_nt_br", 0, 32'h00209463, 1, 1, ex(4'd10, 0, 0, 2'd0, 2'd0, 3'd2, 0));
    fd("bne_t", 32'h00209463, 3'd2);
    cyc("bne_t_br", 0, 32'h00209463, 0, 1, ex(4'd10, 0, 0, 2'd0, 2'd2, 3'd2, 0));
    fd("bgeu", 32'h0020f463, 3'd2);
    cyc("bgeu_br", 0, 32'h0020f463, 0, 0, ex(4'd6, 0, 0, 2'd0, 2'd2, 3'd2, 0));
    fd("blt", 32'h0020c463, 3'd2);
    cyc("blt_br", 0, 32'h0020c463, 1, 0, ex(4'd5, 0, 0, 2'd0, 2'd2, 3'd2, 0));
    fd("lw", 32'h0000a183, 3'd0);
    repeat (4) cyc("lw_wait", 0, 32'h0000a183, 0, 0, mrd(0));
    cyc("lw_done", 0, 32'h0000a183, 0, 1, mrd(1));
    fd("sw", 32'h0020a223, 3'd1);
    repeat (2) cyc("sw_wait", 0, 32'h0020a223, 0, 0, mwr(0));
    cyc("sw_done", 0, 32'h0020a223, 0, 1, mwr(1));
    fd("sw2", 32'h0020a223, 3'd1);
    repeat (2) cyc("sw2_wait", 0, 32'h0020a223, 0, 0, mwr(0));
    cyc("sw2_rst", 1, 32'h0020a223, 0, 0, mwr(0));
    cyc("sw2_abort", 0, 32'h0020a223, 0, 1, '0);
    cyc("sw2_hold", 0, 32'h0020a223, 0, 1, '0);
    fd("ecall", 32'h00000073, 3'd0);
    repeat (3) cyc("ecall_trap", 0, 32'h00000073, 0, 1, trap());
    cyc("trap_rst", 1, 32'h00000073, 0, 1, trap());
    cyc("trap_clr", 0, 32'h00000073, 0, 1, '0);
    cyc("trap_hold", 0, 32'h00000073, 0, 1, '0);
    fd("lb", 32'h00008183, 3'd0);
    repeat (3) cyc("lb_trap", 0, 32'h00008183, 0, 1, trap());
    cyc("lb_rst", 1, 32'h00008183, 0, 1, trap());
    cyc("lb_clr", 0, 32'h00008183, 0, 1, '0);
    @(negedge clk);
    #1;
    chk("drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bean_ctrl_fsm.md
Name: bean_ctrl_fsm

Overview:
- Multicycle control unit for the BEAN-1 RV32I datapath. It fetches, decodes and executes one instruction at a time.
- It drives every datapath select and enable, and runs a req/ready handshake to the shared memory port.
- It reads the latched instruction word from the datapath instruction register and a 1-bit ALU compare flag.
- Supported: LUI, AUIPC, JAL, JALR, BRANCH, LW, SW, OP-IMM, OP and FENCE (FENCE runs as a NOP). Everything else traps.

Parameters:
- RESET_HOLD, 1, idle cycles in S_RESET after reset deasserts before the first fetch (1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- instr  in  32  instruction register contents
- branch_flag  in  1  ALU result bit 0
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  memory write strobe (qualified by mem_req)
- reg_WE  out  1  register file write enable
- rs1_SEL, rs2_SEL, addrs_SEL  out  1 each  mux selects
- reg_SEL, pc_SEL  out  2 each  mux selects
- imm_SEL  out  3  immediate format: 0 I, 1 S, 2 B, 3 U, 4 J
- ALU_MODE  out  4  ALU operation encoding (see Behaviour)
- pc_EN, instr_EN, ALU_mem_EN, mem_in_EN  out  1 each  register and bus-driver enables
- illegal  out  1  sticky trap flag

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high. State register only.
- Output timing: all outputs are combinational Moore/Mealy decode of state, `instr` and `mem_ready`.
- Reset values: state = S_RESET, hold counter = 0, every output 0.
- Reset mid-operation (including mid-handshake) aborts on the next edge; no memory write completes after that edge.
- ALU_MODE encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 EQ, 11 PASS_B.
- OP/OP-IMM mapping: funct3 maps to {ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND}. instr[30] selects SUB (OP only) and SRA (both).
- Default: any output not listed for a state is 0.
- S_RESET: counts RESET_HOLD cycles, then goes to FETCH.
- FETCH:
  - Drives addrs_SEL=1, mem_req=1, mem_in_EN=1, instr_EN=mem_ready.
  - Waits indefinitely while mem_ready=0.
  - On mem_ready goes to DECODE.
- DECODE:
  - One cycle for regfile read; drives imm_SEL for the opcode.
  - Next state: LOAD with funct3=010 → MEM_RD; STORE with funct3=010 → MEM_WR; BRANCH with funct3[2:1]≠01 → BRANCH.
  - Any other supported opcode → EXEC.
  - Anything else → TRAP: unknown opcode, SYSTEM, or bad funct3.
- EXEC (1 cycle, then FETCH). Every instruction here also drives pc_EN=1; pc_SEL=0 unless stated.
  - OP: rs1_SEL=0, rs2_SEL=0, reg_SEL=1, reg_WE=1.
  - OP-IMM: as OP but rs2_SEL=1, imm I.
  - LUI: reg_SEL=2, imm U, reg_WE=1.
  - AUIPC: rs1_SEL=1, rs2_SEL=1, ADD, reg_SEL=1, imm U, reg_WE=1.
  - JAL: reg_SEL=3, pc_SEL=2, imm J, reg_WE=1.
  - JALR: rs2_SEL=1, ADD, imm I, reg_SEL=3, pc_SEL=1, reg_WE=1.
  - FENCE: pc_EN=1 only.
- BRANCH (1 cycle, then FETCH):
  - rs1_SEL=0, rs2_SEL=0, imm B, pc_EN=1.
  - ALU_MODE by funct3[2:1]: 00→EQ, 10→SLT, 11→SLTU.
  - taken = branch_flag XOR funct3[0]; pc_SEL = taken ? 2 : 0.
- MEM_RD:
  - Drives addrs_SEL=0, mem_req=1, mem_in_EN=1.
  - While mem_ready=0: waits, no reg or pc update.
  - On mem_ready: reg_SEL=0, reg_WE=1, pc_EN=1, pc_SEL=0, then FETCH.
- MEM_WR:
  - Drives addrs_SEL=0, mem_req=1, mem_we=1, ALU_mem_EN=1, rs2_SEL=0, ALU_MODE=PASS_B.
  - On mem_ready: pc_EN=1, then FETCH.
- TRAP: all outputs 0 except illegal=1. Stays in TRAP until reset.
- Invariants:
  - mem_in_EN and ALU_mem_EN are never both 1.
  - mem_we=1 implies mem_req=1.
  - pc_EN pulses exactly once per retired instruction.
- mem_ready while mem_req=0 is ignored.

Test Plan:
- Reset: reset held 3 cycles with RESET_HOLD=1 → all outputs 0; mem_req first rises on the 2nd edge after release; addrs_SEL=1.
- ADDI x1,x0,5 (0x00500093) with mem_ready=1 → FETCH/DECODE/EXEC in 3 cycles. EXEC shows rs2_SEL=1, ALU_MODE=0, reg_SEL=1, reg_WE=1, pc_EN=1.
- BNE with branch_flag=1 → ALU_MODE=10, pc_SEL=0. BNE with branch_flag=0 → pc_SEL=2. BGEU → ALU_MODE=6.
- LW with mem_ready low 4 cycles in MEM_RD → mem_req held, reg_WE=0 and pc_EN=0 throughout; 1-cycle reg_WE/pc_EN pulse on the ready cycle.
- SW → mem_we=1, ALU_mem_EN=1, mem_in_EN=0, ALU_MODE=11. Reset asserted mid-wait → outputs 0 next cycle.
- ECALL (0x00000073), then LW with funct3=000 after reset → illegal=1 sticky, mem_req=0 forever, cleared only by reset.
